prog_fsm: RTL and testbench

Table-driven Moore state machine. The next-state function and per-state output are loaded at runtime through a configuration write port instead of being hard-coded. It generalises the fixed five-state, two-bit-input control FSMs used throughout the design: state count, input width and output width are all parameters. It adds run-enable, a state-change pulse and a sticky configuration-error flag.

---
 rtl/prog_fsm_pkg.sv | 27 ++
 rtl/prog_fsm_table.sv | 91 +++++++++
 rtl/prog_fsm.sv | 102 ++++++++++
 tb/tb_prog_fsm.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/prog_fsm_pkg.sv
// Shared constants and types for the table-driven Moore FSM.
// Holds the default parameter values, the state/symbol typedefs for the
// default geometry, the named states of the default five-state machine,
// and a helper that gives the number of table columns for an input width.
package prog_fsm_pkg;

  localparam int DEF_NUM_STATES  = 5;
  localparam int DEF_STATE_W     = 3;
  localparam int DEF_IN_W        = 2;
  localparam int DEF_OUT_W       = 1;
  localparam int DEF_RESET_STATE = 0;

  typedef logic [DEF_STATE_W-1:0] state_t;
  typedef logic [DEF_IN_W-1:0]    sym_t;

  localparam state_t ST_A = 3'd0;
  localparam state_t ST_B = 3'd1;
  localparam state_t ST_C = 3'd2;
  localparam state_t ST_D = 3'd3;
  localparam state_t ST_E = 3'd4;

  // One next-state column per possible input symbol.
  function automatic int tbl_cols(input int in_w);
    return 1 << in_w;
  endfunction

endpackage

// File: rtl/prog_fsm_table.sv
// Flop-based next-state and output tables for prog_fsm, plus the
// configuration write-legality check and the sticky error flag.
// Ports:
//   clk, reset      clock / async active-high reset
//   i_nxt_we        next-state table write strobe
//   i_out_we        output table write strobe
//   i_wr_state      row to write
//   i_wr_sym        column (input symbol) for a next-state write
//   i_wr_next       next-state value to write
//   i_wr_out        output value to write
//   i_rd_state      row to read (current state)
//   i_rd_sym        column to read (current input)
//   o_rd_next       next_table[i_rd_state][i_rd_sym]
//   o_rd_out        out_table[i_rd_state]
//   o_cfg_err       sticky illegal-write flag
module prog_fsm_table
  import prog_fsm_pkg::*;
#(
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int STATE_W    = DEF_STATE_W,
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_nxt_we,
  input  logic               i_out_we,
  input  logic [STATE_W-1:0] i_wr_state,
  input  logic [IN_W-1:0]    i_wr_sym,
  input  logic [STATE_W-1:0] i_wr_next,
  input  logic [OUT_W-1:0]   i_wr_out,
  input  logic [STATE_W-1:0] i_rd_state,
  input  logic [IN_W-1:0]    i_rd_sym,
  output logic [STATE_W-1:0] o_rd_next,
  output logic [OUT_W-1:0]   o_rd_out,
  output logic               o_cfg_err
);

  localparam int LP_COLS = tbl_cols(IN_W);
  // One extra bit so NUM_STATES == 2**STATE_W is representable.
  localparam logic [STATE_W:0] LP_NUM = (STATE_W+1)'(NUM_STATES);

  logic [STATE_W-1:0] r_nxt_tbl [NUM_STATES][LP_COLS];
  logic [OUT_W-1:0]   r_out_tbl [NUM_STATES];
  logic               r_cfg_err;

  logic w_row_ok;
  logic w_next_ok;
  logic w_rd_ok;

  assign w_row_ok  = ({1'b0, i_wr_state} < LP_NUM);
  assign w_next_ok = ({1'b0, i_wr_next}  < LP_NUM);
  assign w_rd_ok   = ({1'b0, i_rd_state} < LP_NUM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // Every row initially points to itself, so an unprogrammed machine holds.
      for (int s = 0; s < NUM_STATES; s++) begin
        r_out_tbl[s] <= '0;
        for (int c = 0; c < LP_COLS; c++) begin
          r_nxt_tbl[s][c] <= STATE_W'(s);
        end
      end
      r_cfg_err <= 1'b0;
    end else begin
      if (i_nxt_we && w_row_ok && w_next_ok) begin
        r_nxt_tbl[i_wr_state][i_wr_sym] <= i_wr_next;
      end
      if (i_out_we && w_row_ok) begin
        r_out_tbl[i_wr_state] <= i_wr_out;
      end
      if ((i_nxt_we && !(w_row_ok && w_next_ok)) || (i_out_we && !w_row_ok)) begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  // The state register can only reach legal rows; the guard keeps the
  // read well-defined for any index value.
  always_comb begin
    o_rd_next = i_rd_state;
    o_rd_out  = '0;
    if (w_rd_ok) begin
      o_rd_next = r_nxt_tbl[i_rd_state][i_rd_sym];
      o_rd_out  = r_out_tbl[i_rd_state];
    end
  end

  assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/prog_fsm.sv
// Table-driven Moore FSM. Next-state and output tables are written at
// runtime through the cfg_* port; the state register advances when en=1.
// Ports:
//   clk, reset      clock / async active-high reset
//   in              input symbol
//   en              run enable (0 holds the state)
//   cfg_nxt_we      next-state table write strobe
//   cfg_out_we      output table write strobe
//   cfg_state       table row to write
//   cfg_in          table column for a next-state write
//   cfg_next        next-state value to write
//   cfg_out         output value to write
//   present_state   current state
//   out             Moore output, out_table[present_state]
//   state_changed   one-cycle pulse after a state change
//   cfg_err         sticky illegal-write flag
//
// state      | meaning
// RESET_STATE| entered on reset; all others defined by the loaded table
// < NUM_STATES| legal, reachable only via table entries
module prog_fsm
  import prog_fsm_pkg::*;
#(
  parameter int NUM_STATES  = DEF_NUM_STATES,
  parameter int STATE_W     = DEF_STATE_W,
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int RESET_STATE = DEF_RESET_STATE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IN_W-1:0]    in,
  input  logic               en,
  input  logic               cfg_nxt_we,
  input  logic               cfg_out_we,
  input  logic [STATE_W-1:0] cfg_state,
  input  logic [IN_W-1:0]    cfg_in,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic [OUT_W-1:0]   cfg_out,
  output logic [STATE_W-1:0] present_state,
  output logic [OUT_W-1:0]   out,
  output logic               state_changed,
  output logic               cfg_err
);

  logic [STATE_W-1:0] r_state;
  logic               r_changed;

  logic [STATE_W-1:0] w_tbl_next;
  logic [OUT_W-1:0]   w_tbl_out;
  logic [STATE_W-1:0] w_state_nxt;
  logic               w_changed_nxt;

  // Reads of the table see the pre-edge contents, so a write on the same
  // edge as a transition only affects later transitions.
  prog_fsm_table #(
    .NUM_STATES (NUM_STATES),
    .STATE_W    (STATE_W),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .i_nxt_we   (cfg_nxt_we),
    .i_out_we   (cfg_out_we),
    .i_wr_state (cfg_state),
    .i_wr_sym   (cfg_in),
    .i_wr_next  (cfg_next),
    .i_wr_out   (cfg_out),
    .i_rd_state (r_state),
    .i_rd_sym   (in),
    .o_rd_next  (w_tbl_next),
    .o_rd_out   (w_tbl_out),
    .o_cfg_err  (cfg_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= STATE_W'(RESET_STATE);
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_changed_nxt = 1'b0;
    if (en) begin
      w_state_nxt   = w_tbl_next;
      w_changed_nxt = (w_tbl_next != r_state);
    end
  end

  always_comb begin
    present_state = r_state;
    out           = w_tbl_out;
    state_changed = r_changed;
  end

endmodule

// File: tb/tb_prog_fsm.sv
module tb_prog_fsm;
  import prog_fsm_pkg::*;

  logic       clk;
  logic       reset;
  sym_t       tb_in;
  logic       en;
  logic       cfg_nxt_we;
  logic       cfg_out_we;
  state_t     cfg_state;
  sym_t       cfg_in;
  state_t     cfg_next;
  logic [0:0] cfg_out;
  state_t     present_state;
  logic [0:0] out;
  logic       state_changed;
  logic       cfg_err;

  prog_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .in            (tb_in),
    .en            (en),
    .cfg_nxt_we    (cfg_nxt_we),
    .cfg_out_we    (cfg_out_we),
    .cfg_state     (cfg_state),
    .cfg_in        (cfg_in),
    .cfg_next      (cfg_next),
    .cfg_out       (cfg_out),
    .present_state (present_state),
    .out           (out),
    .state_changed (state_changed),
    .cfg_err       (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string tag;
    int    st;
    int    o;
    int    chg;
    int    err;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  // bench-side reference tables
  int m_state;
  int m_nxt [8][4];
  int m_out [8];
  int m_err;

  task automatic check(input string tag, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    for (int s = 0; s < 8; s++) begin
      m_out[s] = 0;
      for (int c = 0; c < 4; c++) m_nxt[s][c] = s;
    end
    m_err = 0;
    sb.delete();
  endtask

  task automatic cycle(input string tag, input int sym, input logic en_v,
                       input logic nwe = 1'b0, input logic owe = 1'b0,
                       input int cs = 0, input int ci = 0,
                       input int cn = 0, input int co = 0);
    int   nxt;
    int   chg;
    exp_t e;
    exp_t g;
    @(negedge clk);
    tb_in      = sym_t'(sym);
    en         = en_v;
    cfg_nxt_we = nwe;
    cfg_out_we = owe;
    cfg_state  = state_t'(cs);
    cfg_in     = sym_t'(ci);
    cfg_next   = state_t'(cn);
    cfg_out    = 1'(co);
    nxt = en_v ? m_nxt[m_state][sym] : m_state;
    chg = (nxt != m_state) ? 1 : 0;
    if (nwe) begin
      if (cs < DEF_NUM_STATES && cn < DEF_NUM_STATES) m_nxt[cs][ci] = cn;
      else m_err = 1;
    end
    if (owe) begin
      if (cs < DEF_NUM_STATES) m_out[cs] = co;
      else m_err = 1;
    end
    m_state = nxt;
    e.tag = tag; e.st = m_state; e.o = m_out[m_state]; e.chg = chg; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cfg_nxt_we = 1'b0;
    cfg_out_we = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      g = sb.pop_front();
      check({g.tag, "_state"}, int'(present_state), g.st);
      check({g.tag, "_hier"},  int'(dut.r_state),   g.st);
      check({g.tag, "_out"},   int'(out),           g.o);
      check({g.tag, "_chg"},   int'(state_changed), g.chg);
      check({g.tag, "_err"},   int'(cfg_err),       g.err);
    end
  endtask

  int exp_seq [13] = '{0, 1, 0, 3, 2, 2, 1, 0, 3, 2, 4, 4, 3};
  int in_seq  [13] = '{3, 1, 0, 2, 0, 0, 3, 0, 2, 0, 1, 0, 3};

  initial begin
    reset = 1'b0;
    tb_in = '0; en = 1'b0;
    cfg_nxt_we = 1'b0; cfg_out_we = 1'b0;
    cfg_state = '0; cfg_in = '0; cfg_next = '0; cfg_out = '0;
    model_reset();

    // async reset between edges, no clock edge needed
    #2 reset = 1'b1;
    #1;
    check("rst_state", int'(present_state), 0);
    check("rst_out",   int'(out),           0);
    check("rst_err",   int'(cfg_err),       0);
    check("rst_chg",   int'(state_changed), 0);
    @(negedge clk);
    reset = 1'b0;

    // unprogrammed machine holds
    cycle("hold0", 3, 1'b1);
    cycle("hold1", 1, 1'b1);
    cycle("hold2", 2, 1'b1);

    // program the default machine while stopped
    cycle("pg_a1", 0, 1'b0, 1'b1, 1'b0, ST_A, 3, ST_A);
    cycle("pg_a2", 0, 1'b0, 1'b1, 1'b0, ST_A, 1, ST_B);
    cycle("pg_a3", 0, 1'b0, 1'b1, 1'b0, ST_A, 2, ST_D);
    cycle("pg_b1", 0, 1'b0, 1'b1, 1'b0, ST_B, 0, ST_A);
    cycle("pg_c1", 0, 1'b0, 1'b1, 1'b0, ST_C, 0, ST_C);
    cycle("pg_c2", 0, 1'b0, 1'b1, 1'b0, ST_C, 3, ST_B);
    cycle("pg_c3", 0, 1'b0, 1'b1, 1'b0, ST_C, 1, ST_E);
    cycle("pg_d1", 0, 1'b0, 1'b1, 1'b0, ST_D, 0, ST_C);
    cycle("pg_e1", 0, 1'b0, 1'b1, 1'b0, ST_E, 0, ST_E);
    // both strobes on the same edge
    cycle("pg_e2", 0, 1'b0, 1'b1, 1'b1, ST_E, 3, ST_D, 1);

    for (int k = 0; k < 13; k++) begin
      cycle($sformatf("run%0d", k), in_seq[k], 1'b1);
      check($sformatf("seq%0d", k), int'(present_state), exp_seq[k]);
      check($sformatf("seqout%0d", k), int'(out), (exp_seq[k] == 4) ? 1 : 0);
    end

    // enable hold in D, then release
    cycle("en_off0", 0, 1'b0);
    cycle("en_off1", 0, 1'b0);
    cycle("en_on",   0, 1'b1);
    check("en_on_c", int'(present_state), ST_C);

    // write C[00]=B on the same edge as a C->C transition
    cycle("coll0", 0, 1'b1, 1'b1, 1'b0, ST_C, 0, ST_B);
    check("coll0_c", int'(present_state), ST_C);
    cycle("coll1", 0, 1'b1);
    check("coll1_b", int'(present_state), ST_B);
    cycle("to_a", 0, 1'b1);

    // illegal writes
    cycle("ill_next", 0, 1'b1, 1'b1, 1'b0, ST_A, 0, 5);
    check("ill_next_err", int'(cfg_err), 1);
    cycle("ill_orow", 0, 1'b1, 1'b0, 1'b1, 6, 0, 0, 1);
    cycle("ill_nrow", 0, 1'b1, 1'b1, 1'b0, 6, 0, ST_B);
    cycle("ill_chk0", 0, 1'b1);
    check("ill_a_kept", int'(present_state), ST_A);
    cycle("ill_chk1", 1, 1'b1);
    check("ill_err_sticky", int'(cfg_err), 1);

    // async reset mid-operation clears state, tables and flags
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst2_state", int'(present_state), 0);
    check("rst2_out",   int'(out),           0);
    check("rst2_err",   int'(cfg_err),       0);
    check("rst2_chg",   int'(state_changed), 0);
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst0", 1, 1'b1);
    cycle("post_rst1", 2, 1'b1);
    check("post_rst_hold", int'(present_state), ST_A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
